// File: rtl/udp_line_writer_if.sv
// ---------------------------------------------------------------------------
// udp_line_writer_if
//   Groups the two streams that udp_line_writer sits between:
//     - the assembled UDP payload stream from the nibble-to-16-bit assembler
//       (payload_act, sys_data, sys_en)
//     - the frame-buffer write FIFO port (wr_full, wr_data, wr_en, wr_addr)
//
//   Modports:
//     slave  : the line writer (consumes payload, drives the FIFO write side)
//     master : the environment (drives payload and FIFO-full, observes writes)
// ---------------------------------------------------------------------------
interface udp_line_writer_if #(
    parameter int ADDR_W = 19
);
    logic              payload_act;
    logic [15:0]       sys_data;
    logic              sys_en;
    logic              wr_full;
    logic [15:0]       wr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    modport slave (
        input  payload_act,
        input  sys_data,
        input  sys_en,
        input  wr_full,
        output wr_data,
        output wr_en,
        output wr_addr
    );

    modport master (
        output payload_act,
        output sys_data,
        output sys_en,
        output wr_full,
        input  wr_data,
        input  wr_en,
        input  wr_addr
    );
endinterface

// File: rtl/udp_line_writer.sv
// ---------------------------------------------------------------------------
// udp_line_writer
//   Turns the 16-bit payload words of each received UDP packet (one video
//   line per packet) into addressed pixel writes for the frame-buffer FIFO.
//   The first word of a packet is a line header: bit15 = SOF, bits[9:0] =
//   line index. The following LINE_WORDS words are pixels written to
//   line*LINE_WORDS + word index. Line/frame completion and short-packet /
//   FIFO-overflow errors are reported as one-cycle pulses.
//
//   Ports:
//     phy_clk_rx  MII receive clock, all logic on its rising edge
//     rst_n       asynchronous active-low reset
//     bus         udp_line_writer_if.slave (payload stream in, FIFO writes out)
//     line_done   pulse: line completed with exactly LINE_WORDS words
//     frame_done  pulse with line_done for line LINES-1
//     err_short   pulse: payload ended early (or sequence error)
//     err_ovf     pulse: word dropped because the FIFO was full
//     err_cnt     saturating count of error events
//
//   Optional feature macro: LINE_SEQ_CHK_EN
//     When defined, headers without SOF must carry the expected next line
//     index; a mismatching packet is dropped and reported as err_short.
// ---------------------------------------------------------------------------
module udp_line_writer #(
    parameter int LINE_WORDS = 640,
    parameter int LINES      = 480,
    parameter int ADDR_W     = 19
) (
    input  logic             phy_clk_rx,
    input  logic             rst_n,
    udp_line_writer_if.slave bus,
    output logic             line_done,
    output logic             frame_done,
    output logic             err_short,
    output logic             err_ovf,
    output logic [7:0]       err_cnt
);
    localparam int                CNT_W   = $clog2(LINE_WORDS + 1);
    localparam logic [CNT_W-1:0]  LW_C    = CNT_W'(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LW_A    = ADDR_W'(LINE_WORDS);
    localparam logic [10:0]       LINES_C = 11'(LINES);
    localparam logic [9:0]        LAST_C  = 10'(LINES - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

    state_t            state_q, state_d;
    logic              act_q, act_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [9:0]        line_idx_q, line_idx_d;
    logic              wr_en_q, wr_en_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              line_done_q, line_done_d;
    logic              frame_done_q, frame_done_d;
    logic              err_short_q, err_short_d;
    logic              err_ovf_q, err_ovf_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
`ifdef LINE_SEQ_CHK_EN
    logic [9:0]        exp_q, exp_d;
    logic              seq_err_q, seq_err_d;
`endif

    logic       rise, fall;
    logic [9:0] hdr_idx;
    logic       hdr_ok, hdr_seq_ok, seq_bad;
    logic [8:0] err_sum;

    always_comb begin
        state_d      = state_q;
        act_d        = bus.payload_act;
        cnt_d        = cnt_q;
        base_d       = base_q;
        line_idx_d   = line_idx_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        wr_addr_d    = wr_addr_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        err_short_d  = 1'b0;
        err_ovf_d    = 1'b0;
        seq_bad      = 1'b0;
`ifdef LINE_SEQ_CHK_EN
        exp_d        = exp_q;
        seq_err_d    = seq_err_q;
`endif

        rise    = bus.payload_act & ~act_q;
        fall    = ~bus.payload_act & act_q;
        hdr_idx = bus.sys_data[9:0];
        hdr_ok  = {1'b0, hdr_idx} < LINES_C;
`ifdef LINE_SEQ_CHK_EN
        hdr_seq_ok = bus.sys_data[15] || (hdr_idx == exp_q);
`else
        hdr_seq_ok = 1'b1;
`endif

        case (state_q)
            IDLE: begin
                if (rise) state_d = HDR;
            end

            HDR: begin
                if (bus.sys_en) begin
                    if (!hdr_ok) begin
                        state_d = DROP;
                    end else if (!hdr_seq_ok) begin
                        state_d = DROP;
                        seq_bad = 1'b1;
                    end else begin
                        state_d    = DATA;
                        base_d     = ADDR_W'(hdr_idx) * LW_A;
                        cnt_d      = '0;
                        line_idx_d = hdr_idx;
`ifdef LINE_SEQ_CHK_EN
                        if (bus.sys_data[15]) exp_d = hdr_idx;
`endif
                    end
`ifdef LINE_SEQ_CHK_EN
                    seq_err_d = seq_bad;
`endif
                end
                // A packet ending here has no pixels: short unless the header
                // itself was out of range (a silent drop).
                if (fall) begin
                    err_short_d = !bus.sys_en || (state_d == DATA) || seq_bad;
                    state_d     = IDLE;
                end
            end

            DATA: begin
                if (bus.sys_en && (cnt_q < LW_C)) begin
                    if (bus.wr_full) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = bus.sys_data;
                        wr_addr_d = base_q + ADDR_W'(cnt_q);
                    end
                    // Dropped words still advance so later addresses stay right.
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Completion uses cnt_d so a word arriving with the fall counts.
                if (fall) begin
                    if (cnt_d == LW_C) begin
                        line_done_d  = 1'b1;
                        frame_done_d = (line_idx_q == LAST_C);
`ifdef LINE_SEQ_CHK_EN
                        exp_d = (line_idx_q == LAST_C) ? 10'd0 : line_idx_q + 10'd1;
`endif
                    end else begin
                        err_short_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end

            DROP: begin
                if (fall) begin
`ifdef LINE_SEQ_CHK_EN
                    err_short_d = seq_err_q;
`endif
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        err_sum   = {1'b0, err_cnt_q} + {8'd0, err_short_d} + {8'd0, err_ovf_d};
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // act_q resets high so a payload already in progress when reset is
    // released is not mistaken for a fresh rising edge.
    always_ff @(posedge phy_clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            act_q        <= 1'b1;
            cnt_q        <= '0;
            base_q       <= '0;
            line_idx_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_cnt_q    <= '0;
`ifdef LINE_SEQ_CHK_EN
            exp_q        <= '0;
            seq_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            line_idx_q   <= line_idx_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            err_short_q  <= err_short_d;
            err_ovf_q    <= err_ovf_d;
            err_cnt_q    <= err_cnt_d;
`ifdef LINE_SEQ_CHK_EN
            exp_q        <= exp_d;
            seq_err_q    <= seq_err_d;
`endif
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_addr = wr_addr_q;
    assign line_done   = line_done_q;
    assign frame_done  = frame_done_q;
    assign err_short   = err_short_q;
    assign err_ovf     = err_ovf_q;
    assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_udp_line_writer.sv
// ---------------------------------------------------------------------------
// tb_udp_line_writer
//   Directed bench for udp_line_writer. Packets are driven through the
//   interface; a negedge monitor tallies FIFO writes and status pulses, and
//   the main sequence compares the tallies against hand-computed values.
// ---------------------------------------------------------------------------
module tb_udp_line_writer;
    localparam int LINE_WORDS = 640;
    localparam int LINES      = 480;
    localparam int ADDR_W     = 19;
`ifdef LINE_SEQ_CHK_EN
    localparam logic [15:0] SOFX = 16'h8000;
`else
    localparam logic [15:0] SOFX = 16'h0000;
`endif

    logic       phy_clk_rx = 1'b0;
    logic       rst_n;
    logic       line_done, frame_done, err_short, err_ovf;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    // Monitor tallies
    logic clr_mon = 1'b0;
    int   exp_base = 0;
    int   skip_lo  = -1;
    int   skip_hi  = -1;
    int   wr_cnt, first_addr, last_addr, bad_cnt, skip_seen;
    int   line_cnt, frame_cnt, short_cnt, ovf_cnt, both_cnt;

    always #5 phy_clk_rx = ~phy_clk_rx;

    udp_line_writer_if #(.ADDR_W(ADDR_W)) bus ();

    udp_line_writer #(
        .LINE_WORDS(LINE_WORDS),
        .LINES     (LINES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .phy_clk_rx(phy_clk_rx),
        .rst_n     (rst_n),
        .bus       (bus),
        .line_done (line_done),
        .frame_done(frame_done),
        .err_short (err_short),
        .err_ovf   (err_ovf),
        .err_cnt   (err_cnt)
    );

    // Sample outputs on the falling edge, well away from the active edge.
    always @(negedge phy_clk_rx) begin
        if (clr_mon) begin
            wr_cnt <= 0; first_addr <= -1; last_addr <= -1; bad_cnt <= 0;
            skip_seen <= 0; line_cnt <= 0; frame_cnt <= 0; short_cnt <= 0;
            ovf_cnt <= 0; both_cnt <= 0;
        end else begin
            if (bus.wr_en) begin
                if (wr_cnt == 0) first_addr <= int'(bus.wr_addr);
                last_addr <= int'(bus.wr_addr);
                wr_cnt    <= wr_cnt + 1;
                if (int'(bus.wr_addr) != exp_base + int'(bus.wr_data)) bad_cnt <= bad_cnt + 1;
                if (int'(bus.wr_addr) >= skip_lo && int'(bus.wr_addr) <= skip_hi)
                    skip_seen <= skip_seen + 1;
            end
            if (line_done)              line_cnt  <= line_cnt + 1;
            if (frame_done)             frame_cnt <= frame_cnt + 1;
            if (line_done & frame_done) both_cnt  <= both_cnt + 1;
            if (err_short)              short_cnt <= short_cnt + 1;
            if (err_ovf)                ovf_cnt   <= ovf_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge phy_clk_rx);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clearMon();
        clr_mon = 1'b1;
        tick();
        clr_mon = 1'b0;
    endtask

    task automatic sendWord(input logic [15:0] data, input logic full, input logic end_now);
        bus.sys_data = data;
        bus.sys_en   = 1'b1;
        bus.wr_full  = full;
        if (end_now) bus.payload_act = 1'b0;
        tick();
        bus.sys_en  = 1'b0;
        bus.wr_full = 1'b0;
        repeat (3) tick();
    endtask

    // One packet: header then nwords pixels whose value is their index.
    task automatic applyStimulus(input logic [15:0] hdr, input int nwords,
                                 input int full_lo, input int full_hi,
                                 input bit fall_with_last, input bit chk_lat);
        clearMon();
        bus.payload_act = 1'b1;
        repeat (3) tick();
        sendWord(hdr, 1'b0, 1'b0);
        for (int i = 0; i < nwords; i++) begin
            bus.sys_data = 16'(i);
            bus.sys_en   = 1'b1;
            bus.wr_full  = (i >= full_lo && i <= full_hi);
            if (fall_with_last && i == nwords - 1) bus.payload_act = 1'b0;
            tick();
            bus.sys_en  = 1'b0;
            bus.wr_full = 1'b0;
            if (chk_lat && i == 0) begin
                checkOutput("wr_en_latency", int'(bus.wr_en), 1);
                checkOutput("first_addr_now", int'(bus.wr_addr), exp_base);
            end
            repeat (3) tick();
        end
        bus.payload_act = 1'b0;
        repeat (4) tick();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.payload_act = 1'b0;
        bus.sys_data    = '0;
        bus.sys_en      = 1'b0;
        bus.wr_full     = 1'b0;
        rst_n           = 1'b0;
        repeat (3) tick();
        checkOutput("rst_wr_en", int'(bus.wr_en), 0);
        checkOutput("rst_wr_addr", int'(bus.wr_addr), 0);
        checkOutput("rst_pulses", int'({line_done, frame_done, err_short, err_ovf}), 0);
        checkOutput("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Line 0 with SOF, full line
        $display("[TB] line 0 full");
        exp_base = 0;
        applyStimulus(16'h8000, LINE_WORDS, -1, -1, 1'b0, 1'b1);
        checkOutput("l0_writes", wr_cnt, 640);
        checkOutput("l0_first", first_addr, 0);
        checkOutput("l0_last", last_addr, 639);
        checkOutput("l0_data_addr", bad_cnt, 0);
        checkOutput("l0_line_done", line_cnt, 1);
        checkOutput("l0_frame_done", frame_cnt, 0);
        checkOutput("l0_err_cnt", int'(err_cnt), 0);

        // Last line of frame
        $display("[TB] line 479 frame end");
        exp_base = 306560;
        applyStimulus(16'h01DF | SOFX, LINE_WORDS, -1, -1, 1'b0, 1'b0);
        checkOutput("l479_writes", wr_cnt, 640);
        checkOutput("l479_first", first_addr, 306560);
        checkOutput("l479_last", last_addr, 307199);
        checkOutput("l479_done_with_frame", both_cnt, 1);
        checkOutput("l479_frame_done", frame_cnt, 1);
        checkOutput("l479_err_cnt", int'(err_cnt), 0);

        // Short packet on line 5
        $display("[TB] line 5 short");
        exp_base = 3200;
        applyStimulus(16'h0005 | SOFX, 300, -1, -1, 1'b0, 1'b0);
        checkOutput("l5_writes", wr_cnt, 300);
        checkOutput("l5_first", first_addr, 3200);
        checkOutput("l5_last", last_addr, 3499);
        checkOutput("l5_err_short", short_cnt, 1);
        checkOutput("l5_line_done", line_cnt, 0);
        checkOutput("l5_err_cnt", int'(err_cnt), 1);

        // Line 2 with FIFO full during words 10..12 (err_cnt accumulates: 1 + 3)
        $display("[TB] line 2 overflow");
        exp_base = 1280; skip_lo = 1290; skip_hi = 1292;
        applyStimulus(16'h0002 | SOFX, LINE_WORDS, 10, 12, 1'b0, 1'b0);
        skip_lo = -1; skip_hi = -1;
        checkOutput("l2_writes", wr_cnt, 637);
        checkOutput("l2_skipped_seen", skip_seen, 0);
        checkOutput("l2_last", last_addr, 1919);
        checkOutput("l2_data_addr", bad_cnt, 0);
        checkOutput("l2_err_ovf", ovf_cnt, 3);
        checkOutput("l2_line_done", line_cnt, 1);
        checkOutput("l2_err_cnt", int'(err_cnt), 4);

        // Out-of-range line 480: silently dropped
        $display("[TB] line 480 drop");
        applyStimulus(16'h01E0, LINE_WORDS, -1, -1, 1'b0, 1'b0);
        checkOutput("l480_writes", wr_cnt, 0);
        checkOutput("l480_pulses", line_cnt + frame_cnt + short_cnt + ovf_cnt, 0);
        checkOutput("l480_err_cnt", int'(err_cnt), 4);

        // Line 3, last word arrives in the same cycle as the payload fall
        $display("[TB] line 3 word with fall");
        exp_base = 1920;
        applyStimulus(16'h0003 | SOFX, LINE_WORDS, -1, -1, 1'b1, 1'b0);
        checkOutput("l3_writes", wr_cnt, 640);
        checkOutput("l3_last", last_addr, 2559);
        checkOutput("l3_line_done", line_cnt, 1);
        checkOutput("l3_err_short", short_cnt, 0);
        checkOutput("l3_err_cnt", int'(err_cnt), 4);

        // Reset in the middle of a packet, payload still active afterwards
        $display("[TB] mid-packet reset");
        exp_base = 2560;
        clearMon();
        bus.payload_act = 1'b1;
        repeat (3) tick();
        sendWord(16'h0004 | SOFX, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) sendWord(16'(i), 1'b0, 1'b0);
        checkOutput("rstmid_pre_writes", wr_cnt, 5);
        rst_n = 1'b0;
        tick();
        checkOutput("rstmid_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        clearMon();
        for (int i = 5; i < 8; i++) sendWord(16'(i), 1'b0, 1'b0);
        bus.payload_act = 1'b0;
        repeat (4) tick();
        checkOutput("rstmid_post_writes", wr_cnt, 0);
        checkOutput("rstmid_pulses", line_cnt + short_cnt + ovf_cnt, 0);

        // Normal packet after the aborted one
        $display("[TB] line 1 after reset");
        exp_base = 640;
        applyStimulus(16'h0001 | SOFX, LINE_WORDS, -1, -1, 1'b0, 1'b0);
        checkOutput("l1_writes", wr_cnt, 640);
        checkOutput("l1_first", first_addr, 640);
        checkOutput("l1_line_done", line_cnt, 1);
        checkOutput("l1_err_cnt", int'(err_cnt), 0);

`ifdef LINE_SEQ_CHK_EN
        // Sequence checking: 0 (SOF), 1, then out-of-order 3
        $display("[TB] sequence check");
        doReset();
        exp_base = 0;
        applyStimulus(16'h8000, LINE_WORDS, -1, -1, 1'b0, 1'b0);
        checkOutput("seq0_writes", wr_cnt, 640);
        exp_base = 640;
        applyStimulus(16'h0001, LINE_WORDS, -1, -1, 1'b0, 1'b0);
        checkOutput("seq1_writes", wr_cnt, 640);
        checkOutput("seq1_line_done", line_cnt, 1);
        exp_base = 1920;
        applyStimulus(16'h0003, LINE_WORDS, -1, -1, 1'b0, 1'b0);
        checkOutput("seq3_writes", wr_cnt, 0);
        checkOutput("seq3_err_short", short_cnt, 1);
        checkOutput("seq3_err_cnt", int'(err_cnt), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/udp_line_writer.md
Name: udp_line_writer

Overview:
- Sits directly downstream of the UDP receive path's nibble-to-16-bit assembler, in the phy_clk_rx domain.
- Consumes the 16-bit payload words (sys_data/sys_en) of each received UDP packet; each packet carries one video line.
- Parses a one-word line header, then emits addressed pixel writes into the frame-buffer write FIFO for the SDRAM/VGA side.
- Reports line and frame completion, and reports short-packet and FIFO-overflow errors.

Parameters:
- LINE_WORDS, 640: 16-bit pixel words per line/packet after the header.
- LINES, 480: lines per frame.
- ADDR_W, 19: pixel address width; must satisfy LINES*LINE_WORDS <= 2^ADDR_W.

Ports:
- phy_clk_rx  in  1  MII receive clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- payload_act  in  1  high while the current packet's UDP payload is being received; low between packets.
- sys_data  in  16  assembled payload word, valid when sys_en=1.
- sys_en  in  1  one-cycle strobe per assembled word; strobes are at least 4 cycles apart.
- wr_full  in  1  frame-buffer write FIFO full.
- wr_data  out  16  pixel word to FIFO.
- wr_en  out  1  FIFO write strobe.
- wr_addr  out  ADDR_W  pixel address, line*LINE_WORDS + word index.
- line_done  out  1  one-cycle pulse when a line completes with exactly LINE_WORDS words.
- frame_done  out  1  one-cycle pulse together with line_done for line LINES-1.
- err_short  out  1  one-cycle pulse when payload ends early.
- err_ovf  out  1  one-cycle pulse when a word is dropped on wr_full.
- err_cnt  out  8  saturating count of err_short plus err_ovf events.

Behaviour:
- Reset: every output 0; state IDLE; word counter 0; line base 0.
- The header word uses bit15 = SOF (start of frame) and bits[9:0] = line index. Bits[14:10] are ignored.
- IDLE: on payload_act rising edge (registered compare), go to HDR.
- HDR: the first sys_en captures the header.
  - If the line index is >= LINES, go to DROP.
  - Otherwise latch line_base = index*LINE_WORDS, clear the word counter, and go to DATA.
  - If payload_act falls before any header arrives: return to IDLE and pulse err_short.
- DATA: each sys_en with the counter < LINE_WORDS registers wr_data=sys_data and wr_addr=line_base+counter, and increments the counter.
  - Write latency: wr_en is asserted exactly 1 cycle after sys_en.
  - If wr_full=1 in the sys_en cycle: no write, pulse err_ovf, counter still increments so later addresses stay correct.
  - Words arriving after the counter reaches LINE_WORDS are discarded silently.
  - On payload_act fall:
    - counter == LINE_WORDS: pulse line_done; also pulse frame_done if index == LINES-1.
    - counter < LINE_WORDS: pulse err_short only.
    - Either way, return to IDLE.
- DROP: ignore all words; return to IDLE on payload_act fall; no error pulse.
- If sys_en and the payload_act fall occur in the same cycle, the word is accepted first; completion is evaluated including that word.
- Status pulses are asserted the cycle after the payload_act fall is detected.
- err_cnt increments by 1 per error event and saturates at 255. Simultaneous err_ovf and err_short count as 2, still saturating.
- SOF has no address effect; it is only used by the optional feature.
- Asynchronous reset mid-packet aborts immediately. The next packet is only processed after a fresh payload_act rising edge.

Optional Feature:
- Macro: LINE_SEQ_CHK_EN.
- Defined: line-sequence checking is active.
  - Track the expected next line index. It is set to 0 on reset and to index+1 (mod LINES) after each line_done.
  - A header with SOF=1 resets the expected index to its own index.
  - A header with SOF=0 whose index differs from expected sends the block to DROP, pulses err_short at packet end, and counts 1 in err_cnt.
- Undefined: any in-range index is accepted in any order, and no sequence state is present.

Test Plan:
- Header 0x8000 + 640 words 0x0000..0x027F, wr_full=0 -> 640 writes at addr 0..639, data equals the word index, one line_done, no frame_done, err_cnt=0.
- Header 0x01DF (line 479) + 640 words -> addr 306560..307199, line_done and frame_done pulse in the same cycle.
- Header 0x0005 + 300 words, then payload_act falls -> 300 writes at addr 3200..3499, err_short=1, err_cnt=1, no line_done.
- Header 0x0002 + 640 words with wr_full=1 during words 10..12 -> 637 writes, addr 1290..1292 skipped, err_ovf pulses 3 times, line_done=1, err_cnt=3.
- Header 0x01E0 (line 480) + 640 words -> zero writes, no pulses; next valid packet processes normally.
- LINE_SEQ_CHK_EN defined: headers 0x8000, 0x0001, then 0x0003 -> first two lines written; third gives zero writes, err_short at end, err_cnt=1.
